// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Multiplexed 7-segment display driver. A loaded binary value is converted
//   to BCD one bit per cycle (double-dabble) and committed atomically to a
//   display register. A free-running scanner then steps through NUM_DIGITS
//   digits. Each digit slot starts with an anti-ghost blanking window, and the
//   digit enable is PWM-gated for brightness. Leading zeros can be blanked,
//   each digit has its own DP, and out-of-range values show dashes.
//
//   Ports
//     CLK       system clock
//     RST_N     asynchronous active-low reset
//     value     binary value, captured when a load is accepted
//     dp_mask   per-digit decimal points, captured together with value
//     load      conversion request, accepted only while busy==0
//     busy      conversion in progress
//     lz_blank  blank leading zeros (live input)
//     enable    0 forces all digit enables low; the scan counters keep running
//     bright    PWM duty level, on-fraction (bright+1)/2^BRIGHT_W
//     seg_n     active-low segments, [0]=a .. [6]=g, [7]=dp
//     dig       active-high digit enables, dig[0] = leftmost digit
//
//   Conversion FSM
//     state     | meaning
//     ST_IDLE   | waiting for load; display register holds the last result
//     ST_SHIFT  | VAL_W add-3-then-shift steps on the captured value
//     ST_COMMIT | BCD, dp and ovf copied to the display register in one cycle
module seg7_scan_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int VAL_W        = 16,
   parameter int DIGIT_CYCLES = 16000,
   parameter int BLANK_CYCLES = 160,
   parameter int BRIGHT_W     = 4
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic [VAL_W-1:0]      value,
   input  logic [NUM_DIGITS-1:0] dp_mask,
   input  logic                  load,
   output logic                  busy,
   input  logic                  lz_blank,
   input  logic                  enable,
   input  logic [BRIGHT_W-1:0]   bright,
   output logic [7:0]            seg_n,
   output logic [NUM_DIGITS-1:0] dig
);

   localparam int BCD_W  = 4 * NUM_DIGITS;
   localparam int SLOT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_W  = (VAL_W > 1) ? $clog2(VAL_W) : 1;

   function automatic logic [63:0] max_shown(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) r = r * 64'd10;
      return r - 64'd1;
   endfunction

   localparam logic [63:0] MAX_VAL = max_shown(NUM_DIGITS);

   function automatic logic [6:0] seg_pattern(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h3F;
         4'd1:    return 7'h06;
         4'd2:    return 7'h5B;
         4'd3:    return 7'h4F;
         4'd4:    return 7'h66;
         4'd5:    return 7'h6D;
         4'd6:    return 7'h7D;
         4'd7:    return 7'h07;
         4'd8:    return 7'h7F;
         4'd9:    return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_COMMIT} state_t;

   state_t                  state;
   logic [VAL_W-1:0]        sh;
   logic [BCD_W-1:0]        bcd;
   logic [BCD_W-1:0]        bcd_adj;
   logic [CNT_W-1:0]        bit_cnt;
   logic [NUM_DIGITS-1:0]   dp_cap;
   logic                    ovf_cap;
   logic [BCD_W-1:0]        disp;
   logic [NUM_DIGITS-1:0]   dp_reg;
   logic                    ovf;

   logic [SLOT_W-1:0]       slot_cnt;
   logic [IDX_W-1:0]        idx;
   logic [BRIGHT_W-1:0]     pwm_cnt;

   logic [3:0]              digit_val [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   lead_zero;
   logic                    lead_acc;
   logic [6:0]              seg7;
   logic                    dig_active;
   logic [7:0]              seg_next;
   logic [NUM_DIGITS-1:0]   dig_next;

   // Only the low NUM_DIGITS BCD digits are kept; upper digits never feed
   // back into lower ones, so these stay correct and overflow is flagged
   // separately from the captured value.
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state   <= ST_IDLE;
         busy    <= 1'b0;
         sh      <= '0;
         bcd     <= '0;
         bit_cnt <= '0;
         dp_cap  <= '0;
         ovf_cap <= 1'b0;
         disp    <= '0;
         dp_reg  <= '0;
         ovf     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (load) begin
                  sh      <= value;
                  bcd     <= '0;
                  dp_cap  <= dp_mask;
                  ovf_cap <= (64'(value) > MAX_VAL);
                  bit_cnt <= CNT_W'(VAL_W - 1);
                  busy    <= 1'b1;
                  state   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               bcd <= {bcd_adj[BCD_W-2:0], sh[VAL_W-1]};
               sh  <= sh << 1;
               if (bit_cnt == '0) state <= ST_COMMIT;
               else               bit_cnt <= bit_cnt - 1'b1;
            end
            ST_COMMIT: begin
               disp   <= bcd;
               dp_reg <= dp_cap;
               ovf    <= ovf_cap;
               busy   <= 1'b0;
               state  <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         slot_cnt <= '0;
         idx      <= '0;
         pwm_cnt  <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         if (slot_cnt == SLOT_W'(DIGIT_CYCLES - 1)) begin
            slot_cnt <= '0;
            idx      <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
         end else begin
            slot_cnt <= slot_cnt + 1'b1;
         end
      end
   end

   // Digit 0 is the most significant, i.e. the top nibble of disp.
   always_comb begin
      lead_acc   = 1'b1;
      lead_zero  = '0;
      seg7       = 7'h00;
      seg_next   = 8'hFF;
      dig_next   = '0;
      dig_active = enable && (slot_cnt >= SLOT_W'(BLANK_CYCLES)) && (pwm_cnt <= bright);
      for (int i = 0; i < NUM_DIGITS; i++) begin
         digit_val[i] = disp[4*(NUM_DIGITS-1-i) +: 4];
         lead_acc     = lead_acc && (digit_val[i] == 4'd0);
         lead_zero[i] = lead_acc;
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            if (ovf)
               seg7 = 7'h40;
            else if (lz_blank && (i != NUM_DIGITS - 1) && lead_zero[i])
               seg7 = 7'h00;
            else
               seg7 = seg_pattern(digit_val[i]);
            seg_next    = ~{dp_reg[i], seg7};
            dig_next[i] = dig_active;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         seg_n <= 8'hFF;
         dig   <= '0;
      end else begin
         seg_n <= seg_next;
         dig   <= dig_next;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

   localparam int ND = 4;
   localparam int VW = 16;
   localparam int DC = 40;
   localparam int BC = 8;
   localparam int BW = 4;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic [VW-1:0] value = '0;
   logic [ND-1:0] dp_mask = '0;
   logic          load = 1'b0;
   logic          busy;
   logic          lz_blank = 1'b0;
   logic          enable = 1'b1;
   logic [BW-1:0] bright = '1;
   logic [7:0]    seg_n;
   logic [ND-1:0] dig;

   always #5 CLK = ~CLK;

   seg7_scan_driver #(
      .NUM_DIGITS(ND), .VAL_W(VW), .DIGIT_CYCLES(DC),
      .BLANK_CYCLES(BC), .BRIGHT_W(BW)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .value(value), .dp_mask(dp_mask),
      .load(load), .busy(busy), .lz_blank(lz_blank), .enable(enable),
      .bright(bright), .seg_n(seg_n), .dig(dig)
   );

   int total = 0;
   int bad = 0;

   // Reference model state: k = clock edges since reset release,
   // t_acc = edge at which the latest load was accepted.
   int          k = 0;
   int          t_acc = -100;
   int unsigned old_v = 0, new_v = 0;
   logic [ND-1:0] old_dp = '0, new_dp = '0;

   function automatic int unsigned pow10(input int n);
      int unsigned r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [6:0] pat(input int unsigned d);
      case (d)
         0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
         4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
         8: return 7'h7F; 9: return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   function automatic logic [7:0] seg_model(input int unsigned v, input logic [ND-1:0] dp,
                                            input int i, input bit lz);
      logic [6:0] s;
      if (v > pow10(ND) - 1)                    s = 7'h40;
      else if (lz && i < ND - 1 && v < pow10(ND - 1 - i)) s = 7'h00;
      else                                      s = pat((v / pow10(ND - 1 - i)) % 10);
      return ~{dp[i], s};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
      end
   endtask

   task automatic model_reset();
      k = 0; t_acc = -100;
      old_v = 0; new_v = 0; old_dp = '0; new_dp = '0;
   endtask

   // One clock: snapshot inputs at the edge, check outputs at the falling edge.
   task automatic step();
      logic          ld_s, lz_s, en_s;
      logic [VW-1:0] v_s;
      logic [ND-1:0] dp_s, ddp, edig;
      logic [BW-1:0] br_s;
      int            j, slot, idx, pwm;
      int unsigned   dv;
      bit            ebusy;
      @(posedge CLK);
      ld_s = load; lz_s = lz_blank; en_s = enable; v_s = value; dp_s = dp_mask; br_s = bright;
      @(negedge CLK);
      j = k; k++;
      if (j >= t_acc + VW + 1) begin dv = new_v; ddp = new_dp; end
      else begin dv = old_v; ddp = old_dp; end
      slot = j % DC; idx = (j / DC) % ND; pwm = j % (1 << BW);
      edig = (en_s && slot >= BC && pwm <= int'(br_s)) ? ND'(1 << idx) : '0;
      if (ld_s && !(j >= t_acc && j <= t_acc + VW)) begin
         old_v = new_v; old_dp = new_dp;
         new_v = int'(v_s); new_dp = dp_s; t_acc = k;
      end
      ebusy = (k >= t_acc && k <= t_acc + VW);
      chk("busy", 32'(busy), 32'(ebusy));
      chk("seg_n", 32'(seg_n), 32'(seg_model(dv, ddp, idx, lz_s)));
      chk("dig", 32'(dig), 32'(edig));
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic do_load(input int unsigned v, input logic [ND-1:0] d);
      value = VW'(v); dp_mask = d; load = 1'b1;
      step();
      load = 1'b0;
   endtask

   // Called at a falling edge: assert reset between edges, check the
   // asynchronous effect, release on the next falling edge.
   task automatic async_reset_check();
      #2 RST_N = 1'b0;
      load = 1'b0;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_seg", 32'(seg_n), 32'hFF);
      chk("rst_dig", 32'(dig), 32'd0);
      @(negedge CLK);
      RST_N = 1'b1;
      model_reset();
   endtask

   int nb;

   initial begin
      // Power-up reset, then idle display of 0 with leading-zero blanking.
      lz_blank = 1'b1; enable = 1'b1; bright = '1;
      @(negedge CLK); @(negedge CLK);
      async_reset_check();
      run(ND * DC + 10);

      // 1234, full brightness, check busy width and all four digits.
      lz_blank = 1'b0;
      value = 16'd1234; dp_mask = '0; load = 1'b1;
      nb = 0;
      step();
      if (busy) nb++;
      load = 1'b0;
      repeat (30) begin step(); if (busy) nb++; end
      chk("busy_width", 32'(nb), 32'(VW + 1));
      run(ND * DC);

      // 42 with leading-zero blanking and DP on digit 1.
      lz_blank = 1'b1;
      do_load(42, 4'b0010);
      run(ND * DC + 20);

      // Overflow, with a second load during busy that must be ignored.
      value = 16'd10000; dp_mask = 4'b1000; load = 1'b1;
      nb = 0;
      step();
      if (busy) nb++;
      load = 1'b0;
      repeat (5) begin step(); if (busy) nb++; end
      value = 16'd5; load = 1'b1;
      step(); if (busy) nb++;
      load = 1'b0;
      repeat (25) begin step(); if (busy) nb++; end
      chk("busy_width_ovf", 32'(nb), 32'(VW + 1));
      run(ND * DC);

      // PWM duty and display-off.
      lz_blank = 1'b0; bright = 4'd3;
      do_load(907, 4'b0101);
      run(ND * DC);
      enable = 1'b0;
      run(2 * DC);
      enable = 1'b1; bright = '1;

      // Reset in the middle of a conversion, then a clean conversion.
      do_load(8765, 4'b1111);
      run(6);
      async_reset_check();
      run(10);
      do_load(3019, 4'b0001);
      run(ND * DC);

      // Randomised loads and live-control changes.
      for (int it = 0; it < 24; it++) begin
         lz_blank = 1'($urandom_range(0, 1));
         enable   = ($urandom_range(0, 3) != 0);
         bright   = BW'($urandom_range(0, (1 << BW) - 1));
         if ($urandom_range(0, 2) == 0)
            do_load($urandom_range(0, 99), ND'($urandom_range(0, (1 << ND) - 1)));
         else
            do_load($urandom_range(0, (1 << VW) - 1), ND'($urandom_range(0, (1 << ND) - 1)));
         run($urandom_range(3, 90));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
